// File: rtl/mem_op_ctrl.sv
// Memory-stage controller: one tMemOp at a time onto a req/ack data bus.
// Optional: MEM_MISALIGN_CHK_EN adds oMisalign and rejects misaligned ops.
package corePckg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  opType;
    logic [4:0]  rdAddr;
  } tMemOp;

endpackage

module mem_op_ctrl
  import corePckg::*;
#(
  parameter int pAckTimeout = 16
) (
  input  logic        iClk,
  input  logic        iRstn,
  input  tMemOp       iMemOp,
  input  logic        iOpValid,
  output logic        oOpReady,
  output logic        oBusReq,
  output logic        oBusWe,
  output logic [31:0] oBusAddr,
  output logic [31:0] oBusWData,
  output logic [3:0]  oBusBe,
  input  logic        iBusAck,
  input  logic [31:0] iBusRData,
  output logic        oWbValid,
  output logic [4:0]  oWbAddr,
  output logic [31:0] oWbData,
  output logic        oBusErr
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic        oMisalign
`endif
);

  localparam int CW = $clog2(pAckTimeout + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WB     = 2'd2;

  logic [1:0]    state;
  logic [1:0]    nxt;
  logic [CW-1:0] cnt;

  logic          ld_q;
  logic [2:0]    typ_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;

  logic          accept;
  logic          bus_op;
  logic          mis;
  logic          start;
  logic          ack;
  logic          last;
  logic          tout;
  logic          wb_fire;

  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [31:0]   sh;
  logic [31:0]   ext;

  assign accept = iOpValid & oOpReady;
  assign bus_op = iMemOp.read | iMemOp.write;

`ifdef MEM_MISALIGN_CHK_EN
  assign mis =
    ((iMemOp.opType[1:0] == 2'b01) &
     iMemOp.addr[0]) |
    (iMemOp.opType[1] &
     (|iMemOp.addr[1:0]));
`else
  assign mis = 1'b0;
`endif

  assign start   = accept & bus_op & ~mis;
  assign oBusReq = (state == ACCESS);
  assign ack     = oBusReq & iBusAck;
  assign last    = (cnt == CW'(pAckTimeout - 1));
  assign tout    = oBusReq & ~iBusAck & last;
  assign wb_fire = ack & ld_q & (rd_q != 5'd0);

  // store lanes are fixed at accept so the bus stays stable while req is high
  always_comb begin
    be_n = 4'b0000;
    wd_n = 32'h0;
    unique case (1'b1)
      (iMemOp.opType[1:0] == 2'b00): begin
        be_n = 4'b0001 << iMemOp.addr[1:0];
        wd_n = {4{iMemOp.data[7:0]}};
      end
      (iMemOp.opType[1:0] == 2'b01): begin
        be_n = 4'b0011 << {iMemOp.addr[1], 1'b0};
        wd_n = {2{iMemOp.data[15:0]}};
      end
      iMemOp.opType[1]: begin
        be_n = 4'b1111;
        wd_n = iMemOp.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    sh  = 32'h0;
    ext = 32'h0;
    unique case (1'b1)
      (typ_q[1:0] == 2'b00): begin
        sh  = iBusRData >> {off_q, 3'b000};
        ext = {{24{~typ_q[2] & sh[7]}},
               sh[7:0]};
      end
      (typ_q[1:0] == 2'b01): begin
        sh  = iBusRData >> {off_q[1], 4'b0000};
        ext = {{16{~typ_q[2] & sh[15]}},
               sh[15:0]};
      end
      typ_q[1]: begin
        sh  = iBusRData;
        ext = sh;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (start) nxt = ACCESS;
      end
      ACCESS: begin
        if (ack) nxt = ld_q ? WB : IDLE;
        else if (last) nxt = IDLE;
      end
      WB:      nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state     <= IDLE;
      oOpReady  <= 1'b0;
      cnt       <= '0;
      ld_q      <= 1'b0;
      typ_q     <= 3'b000;
      off_q     <= 2'b00;
      rd_q      <= 5'd0;
      oBusWe    <= 1'b0;
      oBusAddr  <= 32'h0;
      oBusWData <= 32'h0;
      oBusBe    <= 4'b0000;
      oWbValid  <= 1'b0;
      oWbAddr   <= 5'd0;
      oWbData   <= 32'h0;
      oBusErr   <= 1'b0;
    end else begin
      state    <= nxt;
      oOpReady <= (nxt == IDLE);
      oWbValid <= wb_fire;
      oBusErr  <= tout;
      if (start) begin
        ld_q      <= iMemOp.read;
        typ_q     <= iMemOp.opType;
        off_q     <= iMemOp.addr[1:0];
        rd_q      <= iMemOp.rdAddr;
        oBusWe    <= ~iMemOp.read;
        oBusAddr  <= {iMemOp.addr[31:2], 2'b00};
        oBusWData <= wd_n;
        oBusBe    <= be_n;
        cnt       <= '0;
      end else if (oBusReq & ~iBusAck) begin
        cnt <= cnt + 1'b1;
      end
      if (wb_fire) begin
        oWbAddr <= rd_q;
        oWbData <= ext;
      end
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  always_ff @(posedge iClk) begin
    if (!iRstn) oMisalign <= 1'b0;
    else oMisalign <= accept & bus_op & mis;
  end
`endif

endmodule

// File: tb/tb_mem_op_ctrl.sv
// Scoreboard bench for mem_op_ctrl: directed cases plus random ops
// checked against a byte-lane reference model.
module tb_mem_op_ctrl;
  import corePckg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  tMemOp       op;
  logic        opv = 1'b0;
  logic        rdy;
  logic        req;
  logic        we;
  logic [31:0] baddr;
  logic [31:0] bwd;
  logic [3:0]  bbe;
  logic        back = 1'b0;
  logic [31:0] brd = 32'h0;
  logic        wbv;
  logic [4:0]  wba;
  logic [31:0] wbd;
  logic        berr;
`ifdef MEM_MISALIGN_CHK_EN
  logic        misal;
`endif

  mem_op_ctrl #(.pAckTimeout(T)) dut (
    .iClk(clk),
    .iRstn(rstn),
    .iMemOp(op),
    .iOpValid(opv),
    .oOpReady(rdy),
    .oBusReq(req),
    .oBusWe(we),
    .oBusAddr(baddr),
    .oBusWData(bwd),
    .oBusBe(bbe),
    .iBusAck(back),
    .iBusRData(brd),
    .oWbValid(wbv),
    .oWbAddr(wba),
    .oWbData(wbd),
    .oBusErr(berr)
`ifdef MEM_MISALIGN_CHK_EN
    ,
    .oMisalign(misal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
    int          len;
  } bus_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wb_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
  } plan_t;

  bus_t  bus_q[$];
  wb_t   wb_q[$];
  plan_t plan_q[$];
  int    exp_err = 0;
  int    exp_mis = 0;
  int    checks = 0;
  int    errors = 0;
  bit    stray = 1'b0;
  bit    done = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] t);
    if (t[1:0] == 2'b00) return 1;
    if (t[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  // expected load result, from byte-lane arithmetic
  function automatic logic [31:0] load_val(
      input logic [31:0] a, input logic [2:0] t,
      input logic [31:0] rdata);
    int          s;
    int          off;
    logic [31:0] v;
    logic [31:0] m;
    s   = size_of(t);
    off = (int'(a[1:0]) / s) * s;
    v   = rdata >> (8 * off);
    if (s < 4) begin
      m = (32'h1 << (8 * s)) - 1;
      v = v & m;
      if (!t[2] && v[8 * s - 1]) v = v | ~m;
    end
    return v;
  endfunction

  task automatic issue(input logic r, input logic w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [2:0] t,
                       input logic [4:0] rd,
                       input int delay,
                       input logic [31:0] rdata);
    int    s;
    int    off;
    bit    misa;
    bus_t  b;
    plan_t p;
    int    n;
    s    = size_of(t);
    off  = (int'(a[1:0]) / s) * s;
    misa = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
    misa = (int'(a[1:0]) % s) != 0;
`endif
    n = 0;
    @(negedge clk);
    while (!rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL ready_wait: got 0 want 1");
      return;
    end
    if (r | w) begin
      if (misa) begin
        exp_mis++;
      end else begin
        b.addr = {a[31:2], 2'b00};
        b.we   = ~r;
        b.be   = 4'((32'h1 << s) - 1) << off;
        for (int i = 0; i < 4; i++)
          b.wd[8*i +: 8] = d[8*(i % s) +: 8];
        b.len  = (delay < T) ? delay + 1 : T;
        bus_q.push_back(b);
        p.delay = delay;
        p.rdata = rdata;
        plan_q.push_back(p);
        if (delay >= T) exp_err++;
        else if (r && rd != 5'd0)
          wb_q.push_back('{rd, load_val(a, t, rdata)});
      end
    end
    op  = '{r, w, a, d, t, rd};
    opv = 1'b1;
    @(posedge clk);
    #1 opv = 1'b0;
  endtask

  // bus responder
  initial begin
    plan_t cur;
    bit    busy;
    int    k;
    busy = 1'b0;
    k    = 0;
    cur  = '{0, 32'h0};
    forever begin
      @(negedge clk);
      back = 1'b0;
      brd  = $urandom;
      if (busy && !req) busy = 1'b0;
      if (!busy && req && plan_q.size() > 0) begin
        cur  = plan_q.pop_front();
        busy = 1'b1;
        k    = 0;
      end
      if (busy) begin
        if (k == cur.delay) begin
          back = 1'b1;
          brd  = cur.rdata;
          busy = 1'b0;
        end
        k++;
      end else if (stray) begin
        back = 1'b1;
      end
    end
  end

  // bus monitor
  initial begin
    bus_t        cur;
    bit          got;
    bit          stable;
    bit          prev;
    int          len;
    logic [31:0] sa;
    logic [31:0] sw;
    logic [3:0]  sb;
    logic        swe;
    got = 1'b0; stable = 1'b1;
    prev = 1'b0; len = 0;
    sa = 0; sw = 0; sb = 0; swe = 0;
    cur = '{32'h0, 1'b0, 4'h0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (req && !prev) begin
        got = bus_q.size() > 0;
        if (!got) begin
          checks++;
          errors++;
          $display("FAIL bus_unexp: got req want none");
        end else begin
          cur = bus_q.pop_front();
          chk("bus_addr", baddr, cur.addr);
          chk("bus_we", 32'(we), 32'(cur.we));
          chk("bus_be", 32'(bbe), 32'(cur.be));
          if (cur.we) chk("bus_wdata", bwd, cur.wd);
        end
        len = 1; stable = 1'b1;
        sa = baddr; sw = bwd; sb = bbe; swe = we;
      end else if (req) begin
        len++;
        if (baddr !== sa || bwd !== sw ||
            bbe !== sb || we !== swe)
          stable = 1'b0;
      end else if (prev && got) begin
        if (cur.len > 0) chk("req_len", len, cur.len);
        chk("bus_stable", 32'(stable), 32'd1);
      end
      prev = req;
    end
  end

  // writeback, error and misalign monitor
  initial begin
    wb_t w;
    forever begin
      @(negedge clk);
      if (wbv) begin
        if (wb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexp: got rd=%0d want none",
                   wba);
        end else begin
          w = wb_q.pop_front();
          chk("wb_addr", 32'(wba), 32'(w.rd));
          chk("wb_data", wbd, w.d);
        end
      end
      if (berr) begin
        chk("err_exp", 32'(exp_err > 0), 32'd1);
        if (exp_err > 0) exp_err--;
      end
`ifdef MEM_MISALIGN_CHK_EN
      if (misal) begin
        chk("mis_exp", 32'(exp_mis > 0), 32'd1);
        if (exp_mis > 0) exp_mis--;
      end
`endif
    end
  end

  initial begin
    op = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_wb", 32'(wbv), 32'd0);
    chk("rst_addr", baddr, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy), 32'd1);

    // LW, ack 2 cycles after req; check cycle timing
    issue(1, 0, 32'h100, 0, 3'b010, 5, 2, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("lw_req_ack_cyc", 32'(req), 32'd1);
    @(negedge clk);
    chk("lw_wb_cyc", 32'(wbv), 32'd1);
    chk("lw_rdy_wb", 32'(rdy), 32'd0);
    @(negedge clk);
    chk("lw_rdy_after", 32'(rdy), 32'd1);

    issue(1, 0, 32'h203, 0, 3'b000, 7, 1, 32'h80112233);
    issue(1, 0, 32'h203, 0, 3'b100, 8, 0, 32'h80112233);

    // SH with ack in the first req cycle
    issue(0, 1, 32'h302, 32'h0000ABCD, 3'b001, 0, 0, 0);
    @(negedge clk);
    chk("sh_req", 32'(req), 32'd1);
    @(negedge clk);
    chk("sh_rdy_next", 32'(rdy), 32'd1);

    issue(1, 0, 32'h400, 0, 3'b010, 9, 99, 0);
    issue(1, 0, 32'h404, 0, 3'b010, 10, T - 1, 32'h12345678);
    issue(1, 0, 32'h408, 0, 3'b010, 0, 1, 32'hCAFEF00D);
    issue(0, 0, 32'h40C, 0, 3'b010, 3, 0, 0);
    issue(1, 0, 32'h101, 0, 3'b010, 4, 0, 32'h55AA55AA);
    issue(1, 1, 32'h502, 32'h1, 3'b101, 6, 2, 32'h8001_7FFF);

    // reset while req is high, then a stray ack
    issue(1, 0, 32'h600, 0, 3'b010, 11, 99, 0);
    bus_q[bus_q.size() - 1].len = 0;
    exp_err--;
    repeat (3) @(negedge clk);
    chk("mid_req", 32'(req), 32'd1);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_req", 32'(req), 32'd0);
    chk("mid_rst_wbd", wbd, 32'h0);
    chk("mid_rst_be", 32'(bbe), 32'd0);
    rstn  = 1'b1;
    stray = 1'b1;
    repeat (2) @(negedge clk);
    stray = 1'b0;
    chk("stray_rdy", 32'(rdy), 32'd1);
    chk("stray_req", 32'(req), 32'd0);
    @(negedge clk);
    chk("stray_wb", 32'(wbv), 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] rw;
      int         dl;
      int         sel;
      rw  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      dl  = (sel == 0) ? T + 3 :
            (sel == 1) ? T - 1 : $urandom_range(0, 4);
      issue(rw[1], rw[0], $urandom, $urandom,
            3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), dl, $urandom);
    end

    repeat (40) @(negedge clk);
    chk("bus_q_empty", bus_q.size(), 0);
    chk("wb_q_empty", wb_q.size(), 0);
    chk("plan_empty", plan_q.size(), 0);
    chk("err_drained", exp_err, 0);
    chk("mis_drained", exp_mis, 0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL global_timeout: got hang want finish");
      $fatal(1);
    end
  end

endmodule
